lookup_scan_ctrl: RTL and testbench



---
 rtl/lookup_scan_ctrl_pkg.sv | 24 ++
 rtl/lookup_scan_ctrl_if.sv | 50 +++++
 rtl/lookup_scan_ctrl_cell_match.sv | 30 +++
 rtl/lookup_scan_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_lookup_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lookup_scan_ctrl_pkg.sv
// Shared types for the lookup scan engine: FSM encoding, cell record, defaults.
package lookup_scan_ctrl_pkg;

  localparam int DEF_W       = 8;
  localparam int DEF_N_CELLS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Cell record at the default field width; blocks built with a different W
  // declare the same layout locally.
  typedef struct packed {
    logic             elt_def;
    logic [DEF_W-1:0] rank;
    logic [DEF_W-1:0] low;
    logic [DEF_W-1:0] high;
    logic [DEF_W-1:0] index;
    logic [DEF_W-1:0] value;
  } cell_t;

endpackage

// File: rtl/lookup_scan_ctrl_if.sv
// Bus bundle for the scan engine: cell write port, lookup request, response.
interface lookup_scan_ctrl_if
  import lookup_scan_ctrl_pkg::*;
#(
  parameter int N_CELLS = DEF_N_CELLS,
  parameter int W       = DEF_W
);
  localparam int AW = $clog2(N_CELLS);

  logic          wr_en;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic          wr_eltDef;
  logic [W-1:0]  wr_rank;
  logic [W-1:0]  wr_low;
  logic [W-1:0]  wr_high;
  logic [W-1:0]  wr_index;
  logic [W-1:0]  wr_value;

  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_index;
  logic [W-1:0]  req_metadata;
  logic          req_isMetadata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_found;
  logic [W-1:0]  rsp_value;
  logic [W-1:0]  rsp_rank;

  modport master (
    output wr_en, wr_addr, wr_eltDef, wr_rank, wr_low, wr_high, wr_index, wr_value,
    input  wr_ready,
    output req_valid, req_index, req_metadata, req_isMetadata,
    input  req_ready,
    input  rsp_valid, rsp_found, rsp_value, rsp_rank,
    output rsp_ready
  );

  modport slave (
    input  wr_en, wr_addr, wr_eltDef, wr_rank, wr_low, wr_high, wr_index, wr_value,
    output wr_ready,
    input  req_valid, req_index, req_metadata, req_isMetadata,
    output req_ready,
    output rsp_valid, rsp_found, rsp_value, rsp_rank,
    input  rsp_ready
  );

endinterface

// File: rtl/lookup_scan_ctrl_cell_match.sv
// Per-cell match predicate: defined cell, exact index hit, metadata inside
// [low, high] and a metadata-qualified request. Value/rank pass through.
module lookup_cell_match
  import lookup_scan_ctrl_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         elt_def_i,
  input  logic [W-1:0] index_i,
  input  logic [W-1:0] low_i,
  input  logic [W-1:0] high_i,
  input  logic [W-1:0] rank_i,
  input  logic [W-1:0] value_i,
  input  logic [W-1:0] key_i,
  input  logic [W-1:0] meta_i,
  input  logic         is_meta_i,
  output logic         hit_o,
  output logic [W-1:0] rank_o,
  output logic [W-1:0] value_o
);

  // All comparisons unsigned at W bits; both bounds inclusive.
  always_comb begin
    hit_o   = elt_def_i && (index_i == key_i) && (low_i <= meta_i) &&
              (meta_i <= high_i) && is_meta_i;
    rank_o  = rank_i;
    value_o = value_i;
  end

endmodule

// File: rtl/lookup_scan_ctrl.sv
// Sequential lookup scan engine. Holds N_CELLS cells in flops, walks them one
// per clock for each request and reports the highest-rank matching cell.
// The match result of cell[ptr] is registered before the rank reduction, so a
// scan takes N_CELLS+1 cycles from accept to response.
module lookup_scan_ctrl
  import lookup_scan_ctrl_pkg::*;
#(
  parameter int N_CELLS = DEF_N_CELLS,
  parameter int W       = DEF_W
) (
  input  logic              clk,
  input  logic              rst,
  lookup_scan_ctrl_if.slave lk_if
);

  localparam int            AW       = $clog2(N_CELLS);
  localparam logic [AW-1:0] PTR_LAST = AW'(N_CELLS - 1);

  typedef struct packed {
    logic         elt_def;
    logic [W-1:0] rank;
    logic [W-1:0] low;
    logic [W-1:0] high;
    logic [W-1:0] index;
    logic [W-1:0] value;
  } cell_rec_t;

  cell_rec_t     cells_q [N_CELLS];
  cell_rec_t     wr_cell;
  cell_rec_t     cur_cell;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          iss_q, iss_d;          // cells still to be issued this scan
  logic          m_vld_q, m_vld_d;      // registered match stage holds a result
  logic          m_last_q, m_last_d;    // ...and it belongs to the last cell
  logic          m_hit_q, m_hit_d;
  logic [W-1:0]  m_rank_q, m_rank_d;
  logic [W-1:0]  m_value_q, m_value_d;
  logic          found_q, found_d;
  logic [W-1:0]  best_rank_q, best_rank_d;
  logic [W-1:0]  best_value_q, best_value_d;
  logic [W-1:0]  key_q, key_d;
  logic [W-1:0]  meta_q, meta_d;
  logic          is_meta_q, is_meta_d;

  logic          idle;
  logic          wr_fire;
  logic          req_fire;
  logic          hit;
  logic [W-1:0]  hit_rank;
  logic [W-1:0]  hit_value;

  assign idle     = (state_q == ST_IDLE);
  assign wr_fire  = lk_if.wr_en && idle;
  assign req_fire = lk_if.req_valid && idle;

  assign wr_cell  = '{elt_def: lk_if.wr_eltDef, rank: lk_if.wr_rank, low: lk_if.wr_low,
                      high: lk_if.wr_high, index: lk_if.wr_index, value: lk_if.wr_value};
  assign cur_cell = cells_q[ptr_q];

  lookup_cell_match #(.W(W)) u_match (
    .elt_def_i (cur_cell.elt_def),
    .index_i   (cur_cell.index),
    .low_i     (cur_cell.low),
    .high_i    (cur_cell.high),
    .rank_i    (cur_cell.rank),
    .value_i   (cur_cell.value),
    .key_i     (key_q),
    .meta_i    (meta_q),
    .is_meta_i (is_meta_q),
    .hit_o     (hit),
    .rank_o    (hit_rank),
    .value_o   (hit_value)
  );

  // Cell storage; a write landing on the accept edge is seen by the scan,
  // which reads its first cell one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CELLS; i++) cells_q[i] <= '0;
    end else if (wr_fire) begin
      cells_q[lk_if.wr_addr] <= wr_cell;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, scan pointer, match stage and best-match reduction.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    iss_d        = iss_q;
    m_vld_d      = 1'b0;
    m_last_d     = m_last_q;
    m_hit_d      = m_hit_q;
    m_rank_d     = m_rank_q;
    m_value_d    = m_value_q;
    found_d      = found_q;
    best_rank_d  = best_rank_q;
    best_value_d = best_value_q;
    key_d        = key_q;
    meta_d       = meta_q;
    is_meta_d    = is_meta_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          state_d      = ST_SCAN;
          key_d        = lk_if.req_index;
          meta_d       = lk_if.req_metadata;
          is_meta_d    = lk_if.req_isMetadata;
          ptr_d        = '0;
          iss_d        = 1'b1;
          found_d      = 1'b0;
          best_rank_d  = '0;
          best_value_d = '0;
        end
      end
      ST_SCAN: begin
        if (iss_q) begin
          m_vld_d   = 1'b1;
          m_hit_d   = hit;
          m_rank_d  = hit_rank;
          m_value_d = hit_value;
          m_last_d  = (ptr_q == PTR_LAST);
          ptr_d     = ptr_q + 1'b1;
          if (ptr_q == PTR_LAST) iss_d = 1'b0;
        end
        // Strictly-greater keeps the lowest address on rank ties.
        if (m_vld_q && m_hit_q && (!found_q || (m_rank_q > best_rank_q))) begin
          found_d      = 1'b1;
          best_rank_d  = m_rank_q;
          best_value_d = m_value_q;
        end
        if (m_vld_q && m_last_q) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (lk_if.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      iss_q        <= 1'b0;
      m_vld_q      <= 1'b0;
      m_last_q     <= 1'b0;
      m_hit_q      <= 1'b0;
      m_rank_q     <= '0;
      m_value_q    <= '0;
      found_q      <= 1'b0;
      best_rank_q  <= '0;
      best_value_q <= '0;
      key_q        <= '0;
      meta_q       <= '0;
      is_meta_q    <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      iss_q        <= iss_d;
      m_vld_q      <= m_vld_d;
      m_last_q     <= m_last_d;
      m_hit_q      <= m_hit_d;
      m_rank_q     <= m_rank_d;
      m_value_q    <= m_value_d;
      found_q      <= found_d;
      best_rank_q  <= best_rank_d;
      best_value_q <= best_value_d;
      key_q        <= key_d;
      meta_q       <= meta_d;
      is_meta_q    <= is_meta_d;
    end
  end

  // Handshake and response outputs, decoded from registered state only.
  always_comb begin
    lk_if.wr_ready  = idle;
    lk_if.req_ready = idle;
    lk_if.rsp_valid = (state_q == ST_RESP);
    lk_if.rsp_found = (state_q == ST_RESP) && found_q;
    lk_if.rsp_value = '0;
    lk_if.rsp_rank  = '0;
    if ((state_q == ST_RESP) && found_q) begin
      lk_if.rsp_value = best_value_q;
      lk_if.rsp_rank  = best_rank_q;
    end
  end

endmodule

// File: tb/tb_lookup_scan_ctrl.sv
// Bench for lookup_scan_ctrl: directed cases plus a randomized phase, all
// checked by a scoreboard fed from a shadow copy of the cell array.
module tb_lookup_scan_ctrl;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int AW = 4;

  typedef struct {
    logic         def;
    logic [W-1:0] rank, low, high, idx, val;
  } tcell_t;

  typedef struct {
    logic         found;
    logic [W-1:0] val, rank;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lookup_scan_ctrl_if #(.N_CELLS(N), .W(W)) bus ();
  lookup_scan_ctrl #(.N_CELLS(N), .W(W)) dut (.clk(clk), .rst(rst), .lk_if(bus.slave));

  tcell_t shadow [N];
  exp_t   sb [$];
  int     cyc   = 0;
  int     npass = 0;
  int     ntot  = 0;
  bit     rnd_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: among qualifying cells take the maximum rank, then the
  // lowest address carrying that rank.
  function automatic exp_t model(input logic [W-1:0] key, input logic [W-1:0] meta,
                                 input logic ism, input int acc);
    exp_t e;
    int   best = -1;
    bit   q [N];
    e.found = 1'b0; e.val = '0; e.rank = '0; e.acc = acc;
    for (int a = 0; a < N; a++) begin
      q[a] = ism && shadow[a].def && (shadow[a].idx == key) &&
             (meta >= shadow[a].low) && (meta <= shadow[a].high);
      if (q[a] && int'(shadow[a].rank) > best) best = int'(shadow[a].rank);
    end
    for (int a = 0; a < N; a++) begin
      if (!e.found && q[a] && int'(shadow[a].rank) == best) begin
        e.found = 1'b1; e.val = shadow[a].val; e.rank = shadow[a].rank;
      end
    end
    return e;
  endfunction

  function automatic tcell_t mk(input logic d, input logic [W-1:0] idx, input logic [W-1:0] lo,
                                input logic [W-1:0] hi, input logic [W-1:0] val,
                                input logic [W-1:0] rk);
    tcell_t c;
    c.def = d; c.idx = idx; c.low = lo; c.high = hi; c.val = val; c.rank = rk;
    return c;
  endfunction

  task automatic clear_shadow();
    for (int a = 0; a < N; a++) shadow[a] = mk(1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.req_ready && n < 200) begin
      bus.rsp_ready = rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
      n++;
    end
    bus.rsp_ready = 1'b1;
    if (!bus.req_ready) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_cell(input logic [AW-1:0] addr, input tcell_t c);
    bus.wr_addr   = addr;
    bus.wr_eltDef = c.def;
    bus.wr_index  = c.idx;
    bus.wr_low    = c.low;
    bus.wr_high   = c.high;
    bus.wr_value  = c.val;
    bus.wr_rank   = c.rank;
  endtask

  // One IDLE-cycle transaction: optional write, optional request, same edge.
  task automatic issue(input bit dw, input logic [AW-1:0] addr, input tcell_t c,
                       input bit dr, input logic [W-1:0] key, input logic [W-1:0] meta,
                       input logic ism);
    wait_idle();
    if (dw) begin
      drive_cell(addr, c);
      bus.wr_en = 1'b1;
      shadow[addr] = c;
    end
    if (dr) begin
      bus.req_valid      = 1'b1;
      bus.req_index      = key;
      bus.req_metadata   = meta;
      bus.req_isMetadata = ism;
      sb.push_back(model(key, meta, ism, cyc + 1));
    end
    step();
    bus.wr_en     = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Monitor: compares every cycle a response is presented, pops on handshake.
  initial begin : mon
    exp_t e;
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (bus.rsp_valid) begin
          if (sb.size() == 0) begin
            chk("spurious_rsp", 32'd1, 32'd0);
          end else begin
            e = sb[0];
            if (!pv) chk("latency", 32'(cyc - e.acc), 32'(N + 1));
            chk("rsp_found", 32'(bus.rsp_found), 32'(e.found));
            chk("rsp_value", 32'(bus.rsp_value), 32'(e.val));
            chk("rsp_rank",  32'(bus.rsp_rank),  32'(e.rank));
            if (bus.rsp_ready) void'(sb.pop_front());
          end
        end
        pv = bus.rsp_valid && !bus.rsp_ready;
      end
    end
  end

  initial begin : drv
    tcell_t c;
    int     n;
    int     nv;
    bus.wr_en = 1'b0; bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    bus.req_index = '0; bus.req_metadata = '0; bus.req_isMetadata = 1'b0;
    c = mk(1'b0, '0, '0, '0, '0, '0);
    drive_cell('0, c);
    clear_shadow();

    // Reset state.
    step(); step();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_found", 32'(bus.rsp_found), 32'd0);
    chk("rst_rsp_value", 32'(bus.rsp_value), 32'd0);
    chk("rst_rsp_rank",  32'(bus.rsp_rank),  32'd0);
    rst = 1'b0;
    step();
    chk("rst_wr_ready",  32'(bus.wr_ready),  32'd1);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Single match.
    issue(1'b1, 4'd3, mk(1'b1, 8'd5, 8'd10, 8'd20, 8'hAA, 8'd2), 1'b0, '0, '0, 1'b0);
    issue(1'b0, '0, c, 1'b1, 8'd5, 8'd15, 1'b1);
    drain();

    // Rank reduction with a tie; a non-matching higher rank cell too.
    issue(1'b1, 4'd1, mk(1'b1, 8'd7, 8'd0, 8'hFF, 8'h11, 8'd3), 1'b0, '0, '0, 1'b0);
    issue(1'b1, 4'd4, mk(1'b1, 8'd7, 8'd0, 8'hFF, 8'h44, 8'd7), 1'b0, '0, '0, 1'b0);
    issue(1'b1, 4'd9, mk(1'b1, 8'd7, 8'd0, 8'hFF, 8'h99, 8'd7), 1'b0, '0, '0, 1'b0);
    issue(1'b1, 4'd2, mk(1'b1, 8'd8, 8'd0, 8'hFF, 8'h22, 8'd9), 1'b0, '0, '0, 1'b0);
    issue(1'b0, '0, c, 1'b1, 8'd7, 8'd50, 1'b1);

    // Bounds and qualifiers on cell 3 (low 10, high 20).
    issue(1'b0, '0, c, 1'b1, 8'd5, 8'd10, 1'b1);
    issue(1'b0, '0, c, 1'b1, 8'd5, 8'd20, 1'b1);
    issue(1'b0, '0, c, 1'b1, 8'd5, 8'd9,  1'b1);
    issue(1'b0, '0, c, 1'b1, 8'd5, 8'd21, 1'b1);
    issue(1'b0, '0, c, 1'b1, 8'd5, 8'd15, 1'b0);
    issue(1'b1, 4'd3, mk(1'b0, 8'd5, 8'd10, 8'd20, 8'hAA, 8'd2), 1'b1, 8'd5, 8'd15, 1'b1);
    drain();

    // Backpressure: outputs held, request and write ignored while in RESP.
    issue(1'b1, 4'd5, mk(1'b1, 8'h30, 8'd0, 8'hFF, 8'h55, 8'd1), 1'b0, '0, '0, 1'b0);
    issue(1'b0, '0, c, 1'b1, 8'h30, 8'd3, 1'b1);
    bus.rsp_ready = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 40) begin step(); n++; end
    chk("bp_rsp_seen", 32'(bus.rsp_valid), 32'd1);
    repeat (5) begin
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_wr_ready",  32'(bus.wr_ready),  32'd0);
      drive_cell(4'd5, mk(1'b1, 8'h30, 8'd0, 8'hFF, 8'hEE, 8'd15));
      bus.wr_en = 1'b1;
      bus.req_valid = 1'b1; bus.req_index = 8'h30; bus.req_metadata = 8'd3;
      bus.req_isMetadata = 1'b1;
      step();
    end
    bus.wr_en = 1'b0; bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    drain();
    issue(1'b0, '0, c, 1'b1, 8'h30, 8'd3, 1'b1);

    // Simultaneous write and request: scan sees the new contents.
    issue(1'b1, 4'd5, mk(1'b1, 8'h30, 8'd0, 8'hFF, 8'h77, 8'd1), 1'b1, 8'h30, 8'd3, 1'b1);
    drain();

    // Reset in the middle of a scan: no response, cells cleared.
    issue(1'b0, '0, c, 1'b1, 8'h30, 8'd3, 1'b1);
    repeat (4) step();
    rst = 1'b1;
    sb.delete();
    clear_shadow();
    step();
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    rst = 1'b0;
    nv = 0;
    repeat (20) begin step(); if (bus.rsp_valid) nv++; end
    chk("post_rst_no_rsp", 32'(nv), 32'd0);
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    issue(1'b0, '0, c, 1'b1, 8'h30, 8'd3, 1'b1);
    issue(1'b0, '0, c, 1'b1, 8'd0, 8'd0, 1'b1);
    drain();

    // Randomized traffic with random response backpressure.
    rnd_bp = 1'b1;
    repeat (40) begin
      repeat ($urandom_range(0, 2)) begin
        c.def  = ($urandom_range(0, 3) != 0);
        c.idx  = W'($urandom_range(0, 3));
        c.low  = W'($urandom_range(0, 8));
        c.high = W'(int'(c.low) + int'($urandom_range(0, 8)));
        c.rank = W'($urandom_range(0, 3));
        c.val  = W'($urandom_range(0, 255));
        issue(1'b1, AW'($urandom_range(0, N - 1)), c, 1'b0, '0, '0, 1'b0);
      end
      c.def  = 1'b1;
      c.idx  = W'($urandom_range(0, 3));
      c.low  = W'($urandom_range(0, 8));
      c.high = W'(int'(c.low) + int'($urandom_range(0, 8)));
      c.rank = W'($urandom_range(0, 3));
      c.val  = W'($urandom_range(0, 255));
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, N - 1)), c, 1'b1,
            W'($urandom_range(0, 3)), W'($urandom_range(0, 16)),
            ($urandom_range(0, 3) != 0));
    end
    drain();
    rnd_bp = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
